key_sequencer: RTL and testbench
================================

KEY_SEQUENCER -- requirements
Module: key_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, the idle-cycle limit inside a partial scancode sequence.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic in this clock domain.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port rx_data, input, 8, a PS/2 byte from the receiver.
REQ-005 SHALL have port rx_valid, input, 1, a one-cycle strobe qualifying rx_data.
REQ-006 SHALL have port keyCode, output, 32: [31:16] RELEASED or 16'h0000, [15:0] {8'hE0 or 8'h00, code}.
REQ-007 SHALL have port key_valid, output, 1, a one-cycle pulse marking a new keyCode.
REQ-008 SHALL have port frame_err, output, 1, a one-cycle pulse on a protocol error or timeout.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-010 FSM states SHALL be IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0) and SKIP (Pause sequence).
REQ-011 In IDLE, bytes E0->EXT, F0->BRK, E1->SKIP; bytes AA, FA, EE, FE, 00 and FF SHALL be discarded with no output; any other byte emits {16'h0000, 8'h00, byte}.
REQ-012 In EXT, F0->EXT_BRK; any other non-prefix byte emits {16'h0000, 8'hE0, byte} and returns to IDLE.
REQ-013 In BRK, a non-prefix byte emits {RELEASED, 8'h00, byte} and returns to IDLE.
REQ-014 In EXT_BRK, a non-prefix byte emits {RELEASED, 8'hE0, byte} and returns to IDLE.
REQ-015 An unexpected prefix SHALL pulse frame_err and restart the sequence with that prefix as the first byte: E0 goes to EXT, F0 goes to BRK, E1 goes to SKIP. Unexpected prefixes are E0 in EXT/BRK/EXT_BRK, F0 in BRK/EXT_BRK, and E1 outside IDLE.
REQ-016 SKIP SHALL load a 3-bit counter with 7, decrement it on each rx_valid, and return to IDLE with no emit after the 7th byte; byte values are ignored while in SKIP.
REQ-017 Emit latency: keyCode and key_valid SHALL update on the first clk edge after the rx_valid cycle carrying the final byte (1 cycle).
REQ-018 keyCode SHALL hold its last emitted value until the next emit; frame_err and timeouts SHALL NOT alter it.
REQ-019 A timeout counter SHALL clear on every rx_valid and on entry to IDLE, and count every cycle outside IDLE.
REQ-020 When the timeout counter reaches TIMEOUT_CYCLES-1 with rx_valid low, the FSM SHALL go to IDLE and pulse frame_err, with no emit.
REQ-021 If rx_valid coincides with timeout expiry, the byte SHALL win and is processed normally, with no frame_err.
REQ-022 The timeout counter SHALL saturate and never wrap; its width SHALL be $clog2(TIMEOUT_CYCLES).
REQ-023 key_valid and frame_err SHALL never both be high in the same cycle; an emit and an error cannot occur on one byte.
REQ-024 Back-to-back rx_valid on consecutive cycles SHALL be accepted with no byte loss.

Reset
REQ-025 On rst_n low, the block SHALL asynchronously force: state=IDLE, keyCode=32'h0, key_valid=0, frame_err=0, busy=0, and both counters cleared.
REQ-026 Reset asserted mid-sequence SHALL discard the partial sequence; the first byte after release SHALL be decoded from IDLE.

Structure
REQ-027 keyboard_pkg SHALL hold RELEASED (16'h00F0) and new 8-bit constants PFX_EXT=8'hE0, PFX_BRK=8'hF0 and PFX_PAUSE=8'hE1.
REQ-028 keyboard_pkg SHALL also hold the FSM state enum typedef.
REQ-029 The block SHALL contain one sub-module, seq_timeout, the saturating timeout counter with clear and expire outputs; everything else is flat.
REQ-030 keyCode SHALL drive key_decoder.keyCode directly; no other glue is permitted.

Verification
REQ-031 Bytes 1C then F0 1C -> key_valid twice; keyCode=32'h0000_001C, then 32'h00F0_001C.
REQ-032 Bytes E0 75 then E0 F0 75 -> keyCode=32'h0000_E075, then 32'h00F0_E075, each one cycle after the last byte.
REQ-033 Byte E0, then idle for TIMEOUT_CYCLES (set to 16) -> frame_err pulse at cycle 15, busy falls, and keyCode unchanged. A second run with a byte arriving at cycle 15 -> no frame_err.
REQ-034 Bytes E1 14 77 E1 F0 14 F0 77 then 29 -> no emit for the Pause bytes; keyCode=32'h0000_0029 after the 29.
REQ-035 Bytes F0 F0 1C -> one frame_err after the second F0, then keyCode=32'h00F0_001C.
REQ-036 Bytes E0 F0, then rst_n pulsed low, then 1C -> all outputs 0 during reset, then keyCode=32'h0000_001C.

Source files
------------

// File: rtl/keyboard_pkg.sv
// Shared constants and the FSM state type for the PS/2 scancode sequencer.
package keyboard_pkg;

  localparam logic [15:0] RELEASED  = 16'h00F0;
  localparam logic [7:0]  PFX_EXT   = 8'hE0;
  localparam logic [7:0]  PFX_BRK   = 8'hF0;
  localparam logic [7:0]  PFX_PAUSE = 8'hE1;

  // Number of bytes that follow E1 in the Pause sequence.
  localparam logic [2:0]  PAUSE_TAIL = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } seq_state_t;

  // Keyboard status/ack bytes that carry no key information.
  function automatic logic is_discard(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/seq_timeout.sv
// Saturating idle-cycle counter; flags expiry once the limit is reached while running.
module seq_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count while running, hold at zero when idle or on a new byte, stick at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !run) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = run && (cnt == LIMIT);

endmodule

// File: rtl/key_sequencer.sv
// Assembles PS/2 scancode bytes (E0/F0 prefixes, Pause sequence) into 32-bit key codes.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | waiting for the first byte of a sequence
// ST_EXT     | E0 seen, expecting F0 or the key byte
// ST_BRK     | F0 seen, expecting the key byte
// ST_EXT_BRK | E0 F0 seen, expecting the key byte
// ST_SKIP    | E1 seen, swallowing the rest of the Pause sequence
module key_sequencer
  import keyboard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] keyCode,
  output logic        key_valid,
  output logic        frame_err,
  output logic        busy
);

  seq_state_t state;
  logic [2:0] skip_cnt;
  logic       expire;
  logic       in_seq;
  logic       timeout_hit;

  assign in_seq      = (state != ST_IDLE);
  assign busy        = in_seq;
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign timeout_hit = expire && !rx_valid;

  seq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_seq_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (rx_valid),
    .run   (in_seq),
    .expire(expire)
  );

  // Sequence FSM with registered key/error outputs; keyCode only changes on an emit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      skip_cnt  <= 3'd0;
      keyCode   <= 32'h0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (rx_valid) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == PFX_EXT) begin
              state <= ST_EXT;
            end else if (rx_data == PFX_BRK) begin
              state <= ST_BRK;
            end else if (rx_data == PFX_PAUSE) begin
              state    <= ST_SKIP;
              skip_cnt <= PAUSE_TAIL;
            end else if (!is_discard(rx_data)) begin
              keyCode   <= {16'h0000, 8'h00, rx_data};
              key_valid <= 1'b1;
            end
          end
          ST_EXT: begin
            if (rx_data == PFX_BRK) begin
              state <= ST_EXT_BRK;
            end else if (rx_data == PFX_EXT) begin
              frame_err <= 1'b1;
            end else if (rx_data == PFX_PAUSE) begin
              frame_err <= 1'b1;
              state     <= ST_SKIP;
              skip_cnt  <= PAUSE_TAIL;
            end else begin
              keyCode   <= {16'h0000, PFX_EXT, rx_data};
              key_valid <= 1'b1;
              state     <= ST_IDLE;
            end
          end
          ST_BRK, ST_EXT_BRK: begin
            // Any prefix here restarts the sequence with that prefix as its first byte.
            if (rx_data == PFX_EXT) begin
              frame_err <= 1'b1;
              state     <= ST_EXT;
            end else if (rx_data == PFX_BRK) begin
              frame_err <= 1'b1;
              state     <= ST_BRK;
            end else if (rx_data == PFX_PAUSE) begin
              frame_err <= 1'b1;
              state     <= ST_SKIP;
              skip_cnt  <= PAUSE_TAIL;
            end else begin
              keyCode   <= {RELEASED, (state == ST_EXT_BRK) ? PFX_EXT : 8'h00, rx_data};
              key_valid <= 1'b1;
              state     <= ST_IDLE;
            end
          end
          ST_SKIP: begin
            if (skip_cnt <= 3'd1) begin
              skip_cnt <= 3'd0;
              state    <= ST_IDLE;
            end else begin
              skip_cnt <= skip_cnt - 3'd1;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end else if (timeout_hit) begin
        state     <= ST_IDLE;
        skip_cnt  <= 3'd0;
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_sequencer.sv
// Directed bench for key_sequencer with hand-computed expected key codes.
module tb_key_sequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] keyCode;
  logic        key_valid;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  key_sequencer #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .keyCode  (keyCode),
    .key_valid(key_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one byte for one cycle, starting and ending on a falling edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // key_valid and frame_err must never coincide.
  always @(negedge clk) begin
    if (rst_n && (key_valid || frame_err))
      check_eq("kv_fe_exclusive", {31'b0, key_valid & frame_err}, 32'h0);
  end

  initial begin
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    check_eq("rst_keycode", keyCode, 32'h0);
    check_eq("rst_kv", {31'b0, key_valid}, 32'h0);
    check_eq("rst_fe", {31'b0, frame_err}, 32'h0);
    check_eq("rst_busy", {31'b0, busy}, 32'h0);
    rst_n = 1'b1;
    idle(1);

    // Make and break of a plain key.
    send(8'h1C);
    check_eq("make_kv", {31'b0, key_valid}, 32'h1);
    check_eq("make_code", keyCode, 32'h0000_001C);
    check_eq("make_busy", {31'b0, busy}, 32'h0);
    send(8'hF0);
    check_eq("brk_pfx_kv", {31'b0, key_valid}, 32'h0);
    check_eq("brk_pfx_busy", {31'b0, busy}, 32'h1);
    check_eq("brk_pfx_hold", keyCode, 32'h0000_001C);
    send(8'h1C);
    check_eq("break_kv", {31'b0, key_valid}, 32'h1);
    check_eq("break_code", keyCode, 32'h00F0_001C);
    idle(1);
    check_eq("kv_pulse", {31'b0, key_valid}, 32'h0);

    // Extended make and break.
    send(8'hE0);
    check_eq("ext_busy", {31'b0, busy}, 32'h1);
    send(8'h75);
    check_eq("ext_make_kv", {31'b0, key_valid}, 32'h1);
    check_eq("ext_make_code", keyCode, 32'h0000_E075);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check_eq("ext_break_kv", {31'b0, key_valid}, 32'h1);
    check_eq("ext_break_code", keyCode, 32'h00F0_E075);

    // Status byte is swallowed.
    send(8'hAA);
    check_eq("discard_kv", {31'b0, key_valid}, 32'h0);
    check_eq("discard_code", keyCode, 32'h00F0_E075);
    check_eq("discard_busy", {31'b0, busy}, 32'h0);

    // Timeout: 16 idle cycles after E0, error registered off the 16th.
    idle(1);
    send(8'hE0);
    idle(15);
    check_eq("to_pre_fe", {31'b0, frame_err}, 32'h0);
    check_eq("to_pre_busy", {31'b0, busy}, 32'h1);
    idle(1);
    check_eq("to_fe", {31'b0, frame_err}, 32'h1);
    check_eq("to_busy", {31'b0, busy}, 32'h0);
    check_eq("to_code_hold", keyCode, 32'h00F0_E075);
    check_eq("to_kv", {31'b0, key_valid}, 32'h0);
    idle(1);
    check_eq("to_fe_pulse", {31'b0, frame_err}, 32'h0);

    // Byte on the expiry cycle wins.
    send(8'hE0);
    idle(15);
    send(8'h75);
    check_eq("to_race_fe", {31'b0, frame_err}, 32'h0);
    check_eq("to_race_kv", {31'b0, key_valid}, 32'h1);
    check_eq("to_race_code", keyCode, 32'h0000_E075);

    // Pause sequence produces nothing, then a normal key.
    idle(1);
    for (int i = 0; i < 8; i++) begin
      send(pause_seq[i]);
      check_eq($sformatf("pause_kv_%0d", i), {31'b0, key_valid}, 32'h0);
      check_eq($sformatf("pause_fe_%0d", i), {31'b0, frame_err}, 32'h0);
    end
    check_eq("pause_done_busy", {31'b0, busy}, 32'h0);
    send(8'h29);
    check_eq("after_pause_kv", {31'b0, key_valid}, 32'h1);
    check_eq("after_pause_code", keyCode, 32'h0000_0029);

    // Repeated F0 restarts the break sequence.
    send(8'hF0);
    check_eq("ff_first_fe", {31'b0, frame_err}, 32'h0);
    send(8'hF0);
    check_eq("ff_second_fe", {31'b0, frame_err}, 32'h1);
    check_eq("ff_second_busy", {31'b0, busy}, 32'h1);
    check_eq("ff_code_hold", keyCode, 32'h0000_0029);
    send(8'h1C);
    check_eq("ff_kv", {31'b0, key_valid}, 32'h1);
    check_eq("ff_fe_clear", {31'b0, frame_err}, 32'h0);
    check_eq("ff_code", keyCode, 32'h00F0_001C);

    // E0 inside E0 F0 restarts as extended.
    send(8'hE0);
    send(8'hF0);
    send(8'hE0);
    check_eq("efe_fe", {31'b0, frame_err}, 32'h1);
    send(8'h11);
    check_eq("efe_code", keyCode, 32'h0000_E011);
    check_eq("efe_kv", {31'b0, key_valid}, 32'h1);

    // E1 inside a break sequence jumps into Pause skipping.
    send(8'hF0);
    send(8'hE1);
    check_eq("brk_e1_fe", {31'b0, frame_err}, 32'h1);
    check_eq("brk_e1_busy", {31'b0, busy}, 32'h1);
    for (int i = 0; i < 7; i++) send(8'h5A);
    check_eq("brk_e1_done_busy", {31'b0, busy}, 32'h0);
    check_eq("brk_e1_code_hold", keyCode, 32'h0000_E011);

    // Reset mid-sequence clears everything asynchronously.
    send(8'hE0);
    send(8'hF0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_code", keyCode, 32'h0);
    check_eq("mid_rst_busy", {31'b0, busy}, 32'h0);
    check_eq("mid_rst_kv", {31'b0, key_valid}, 32'h0);
    check_eq("mid_rst_fe", {31'b0, frame_err}, 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send(8'h1C);
    check_eq("post_rst_kv", {31'b0, key_valid}, 32'h1);
    check_eq("post_rst_code", keyCode, 32'h0000_001C);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
